// File: rtl/multicycle_mainfsm.sv
// multicycle_mainfsm: main control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle ARM datapath.
module multicycle_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;
  state_t state, next_state, dec;
  logic next_pc, reg_w, mem_w, branch, no_write;
  always_ff @(posedge clk)
    state <= reset ? FETCH : next_state;
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:              next_state = DECODE;
      DECODE:             next_state = Op == 2'b01 ? MEMADR :
                                       Op == 2'b10 ? BRANCH :
                                       Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) : FETCH;
      MEMADR:             next_state = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            next_state = MEMWB;
      EXECUTER, EXECUTEI: next_state = ALUWB;
      default:            next_state = FETCH;
    endcase
  end
  // During reset the mux selects decode as FETCH so the datapath sees fetch values
  assign dec = reset ? FETCH : state;
  always_comb begin
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    case (dec)
      FETCH: begin
        next_pc   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end
  // CMP only sets flags, so its writeback must not touch the register file
  assign no_write = (state == ALUWB) && (Funct[4:1] == 4'b1010);
  assign IRWrite  = ~reset & (dec == FETCH);
  assign RegWrite = ~reset & reg_w & CondEx & ~no_write;
  assign MemWrite = ~reset & mem_w & CondEx;
  assign PCWrite  = ~reset & (next_pc | (branch & CondEx));
  assign State    = state;
endmodule

// File: tb/tb_multicycle_mainfsm.sv
// tb_multicycle_mainfsm: directed table, corner sequences and random instructions against a path/rule model.
module tb_multicycle_mainfsm;
  logic       clk = 1'b0;
  logic       reset, CondEx;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUOp, RegWrite, MemWrite, PCWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  multicycle_mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .CondEx(CondEx),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       pcw;
  } out_t;

  typedef int q_t[$];

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic       c;
    int         cyc;
    int         rw;
    int         mw;
    int         pw;
    string      name;
  } vec_t;

  out_t act;
  assign act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegWrite, MemWrite, PCWrite};

  out_t mux_tab [10];
  vec_t tab [10];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs: selects from the per-state table, strobes from the gating rules
  function automatic out_t model(input int s, input logic [5:0] f, input logic c, input logic rst);
    int   e;
    out_t o;
    e = rst ? 0 : s;
    o = (e < 10) ? mux_tab[e] : '0;
    o.irw  = !rst && e == 0;
    o.pcw  = !rst && (e == 0 || (e == 9 && c));
    o.regw = !rst && c && (e == 4 || (e == 8 && f[4:1] != 4'b1010));
    o.memw = !rst && c && e == 5;
    return o;
  endfunction

  function automatic q_t path_of(input logic [1:0] op, input logic [5:0] f);
    q_t p;
    p.push_back(0);
    p.push_back(1);
    case (op)
      2'b00: begin
        p.push_back(f[5] ? 7 : 6);
        p.push_back(8);
      end
      2'b01: begin
        p.push_back(2);
        if (f[0]) begin
          p.push_back(3);
          p.push_back(4);
        end else p.push_back(5);
      end
      2'b10: p.push_back(9);
      default: ;
    endcase
    return p;
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic c, input string tag,
                           output int cyc, output int rw, output int mw, output int pw);
    q_t p;
    p = path_of(op, f);
    Op = op;
    Funct = f;
    CondEx = c;
    #1;
    cyc = 0;
    rw = 0;
    mw = 0;
    pw = 0;
    do begin
      if (cyc < p.size()) begin
        chk({tag, " state"}, 32'(State), 32'(p[cyc]));
        chk({tag, " outs"}, 32'(act), 32'(model(p[cyc], f, c, 1'b0)));
      end
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      pw += int'(PCWrite);
      step;
      cyc++;
    end while (State != 4'd0 && cyc < 12);
    chk({tag, " cpi"}, 32'(cyc), 32'(p.size()));
  endtask

  initial begin
    int cyc, rw, mw, pw;
    logic [1:0] op;
    logic [5:0] f;
    logic c;
    mux_tab[0] = '{irw:0, adr:0, srca:2'b01, srcb:2'b10, res:2'b10, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[1] = '{irw:0, adr:0, srca:2'b01, srcb:2'b10, res:2'b10, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[2] = '{irw:0, adr:0, srca:2'b00, srcb:2'b01, res:2'b00, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[3] = '{irw:0, adr:1, srca:2'b00, srcb:2'b00, res:2'b00, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[4] = '{irw:0, adr:0, srca:2'b00, srcb:2'b00, res:2'b01, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[5] = '{irw:0, adr:1, srca:2'b00, srcb:2'b00, res:2'b00, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[6] = '{irw:0, adr:0, srca:2'b00, srcb:2'b00, res:2'b00, aluop:1, regw:0, memw:0, pcw:0};
    mux_tab[7] = '{irw:0, adr:0, srca:2'b00, srcb:2'b01, res:2'b00, aluop:1, regw:0, memw:0, pcw:0};
    mux_tab[8] = '{irw:0, adr:0, srca:2'b00, srcb:2'b00, res:2'b00, aluop:0, regw:0, memw:0, pcw:0};
    mux_tab[9] = '{irw:0, adr:0, srca:2'b00, srcb:2'b01, res:2'b10, aluop:0, regw:0, memw:0, pcw:0};
    tab[0] = '{2'b00, 6'b001000, 1'b1, 4, 1, 0, 1, "add_reg"};
    tab[1] = '{2'b00, 6'b110101, 1'b1, 4, 0, 0, 1, "cmp_imm"};
    tab[2] = '{2'b00, 6'b010101, 1'b1, 4, 0, 0, 1, "cmp_reg"};
    tab[3] = '{2'b01, 6'b011001, 1'b1, 5, 1, 0, 1, "ldr"};
    tab[4] = '{2'b01, 6'b011000, 1'b1, 4, 0, 1, 1, "str"};
    tab[5] = '{2'b10, 6'b000000, 1'b1, 3, 0, 0, 2, "b_taken"};
    tab[6] = '{2'b10, 6'b000000, 1'b0, 3, 0, 0, 1, "b_nottaken"};
    tab[7] = '{2'b00, 6'b101000, 1'b0, 4, 0, 0, 1, "add_imm_nc"};
    tab[8] = '{2'b01, 6'b011000, 1'b0, 4, 0, 0, 1, "str_nc"};
    tab[9] = '{2'b11, 6'b111111, 1'b1, 2, 0, 0, 1, "op11"};

    reset = 1'b1;
    CondEx = 1'b1;
    Op = 2'b00;
    Funct = 6'b000000;
    #1;
    chk("reset pre-edge outs", 32'(act), 32'(model(0, Funct, 1'b1, 1'b1)));
    step;
    chk("reset state", 32'(State), 32'd0);
    chk("reset outs", 32'(act), 32'(model(0, Funct, 1'b1, 1'b1)));
    step;
    chk("reset state 2", 32'(State), 32'd0);
    reset = 1'b0;
    #1;
    chk("post reset IRWrite", 32'(IRWrite), 32'd1);
    chk("post reset PCWrite", 32'(PCWrite), 32'd1);

    foreach (tab[i]) begin
      run_instr(tab[i].op, tab[i].f, tab[i].c, tab[i].name, cyc, rw, mw, pw);
      chk({tab[i].name, " cycles"}, 32'(cyc), 32'(tab[i].cyc));
      chk({tab[i].name, " regwrites"}, 32'(rw), 32'(tab[i].rw));
      chk({tab[i].name, " memwrites"}, 32'(mw), 32'(tab[i].mw));
      chk({tab[i].name, " pcwrites"}, 32'(pw), 32'(tab[i].pw));
    end

    // Reset arriving in MEMREAD must abort the load without a write pulse
    Op = 2'b01;
    Funct = 6'b011001;
    CondEx = 1'b1;
    step;
    step;
    step;
    chk("abort at memread", 32'(State), 32'd3);
    reset = 1'b1;
    #1;
    chk("abort RegWrite", 32'(RegWrite), 32'd0);
    chk("abort outs", 32'(act), 32'(model(3, Funct, 1'b1, 1'b1)));
    step;
    chk("abort state", 32'(State), 32'd0);
    chk("abort RegWrite 2", 32'(RegWrite), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort resume outs", 32'(act), 32'(model(0, Funct, 1'b1, 1'b0)));

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      c = 1'($urandom_range(0, 1));
      run_instr(op, f, c, "rand", cyc, rw, mw, pw);
      chk("rand regwrites", 32'(rw), 32'(c && ((op == 2'b01 && f[0]) || (op == 2'b00 && f[4:1] != 4'b1010))));
      chk("rand memwrites", 32'(mw), 32'(c && op == 2'b01 && !f[0]));
      chk("rand pcwrites", 32'(pw), 32'(1 + int'(op == 2'b10 && c)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
